// File: rtl/axil_master_ctrl.sv
// AXI4-Lite master: one register command at a time in, one held response out.
// Optional wait-state abort enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RDATA, S_RSP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done, w_done;
    logic              cmd_fire, aw_hs, w_hs, wr_req_done;
    logic              tmo, abort;

    assign cmd_fire    = cmd_valid & (state == S_IDLE);
    assign aw_hs       = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID & M_AXI_WREADY;
    assign wr_req_done = (aw_done | aw_hs) & (w_done | w_hs);

`ifdef AXIL_MST_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        timeout_q;

    assign waiting = (state == S_WREQ) | (state == S_WRESP) | (state == S_RREQ) | (state == S_RDATA);
    assign tmo     = waiting & (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN)  wait_cnt <= '0;
        else if (cmd_fire)   wait_cnt <= '0;
        else if (waiting)    wait_cnt <= wait_cnt + 16'd1;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) timeout_q <= 1'b0;
        else if (cmd_fire)  timeout_q <= 1'b0;
        else if (abort)     timeout_q <= 1'b1;
    end
    assign rsp_timeout = timeout_q;
`else
    assign tmo         = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // A handshake completing in the limit cycle wins over the abort.
    assign abort = tmo & (((state == S_WREQ)  & ~wr_req_done)   |
                          ((state == S_WRESP) & ~M_AXI_BVALID)  |
                          ((state == S_RREQ)  & ~M_AXI_ARREADY) |
                          ((state == S_RDATA) & ~M_AXI_RVALID));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_fire) state_nxt = cmd_write ? S_WREQ : S_RREQ;
            S_WREQ:  if (abort) state_nxt = S_RSP; else if (wr_req_done) state_nxt = S_WRESP;
            S_WRESP: if (abort || M_AXI_BVALID) state_nxt = S_RSP;
            S_RREQ:  if (abort) state_nxt = S_RSP; else if (M_AXI_ARREADY) state_nxt = S_RDATA;
            S_RDATA: if (abort || M_AXI_RVALID) state_nxt = S_RSP;
            S_RSP:   if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        case (state)
            S_IDLE:  cmd_ready     = 1'b1;
            S_WREQ:  begin
                M_AXI_AWVALID = ~aw_done;
                M_AXI_WVALID  = ~w_done;
            end
            S_WRESP: M_AXI_BREADY  = 1'b1;
            S_RREQ:  M_AXI_ARVALID = 1'b1;
            S_RDATA: M_AXI_RREADY  = 1'b1;
            S_RSP:   rsp_valid     = 1'b1;
            default: ;
        endcase
    end

    // Payload registers only load on accept, so they stay put while any VALID is up.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
        end else if (abort) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
        end else begin
            case (state)
                S_IDLE: if (cmd_fire) begin
                    addr_q  <= cmd_addr & ~ADDR_W'(3);
                    wdata_q <= cmd_wdata;
                    wstrb_q <= cmd_wstrb;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
                S_WREQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                S_WRESP: if (M_AXI_BVALID) begin
                    rsp_rdata <= '0;
                    rsp_resp  <= M_AXI_BRESP;
                end
                S_RDATA: if (M_AXI_RVALID) begin
                    rsp_rdata <= M_AXI_RDATA;
                    rsp_resp  <= M_AXI_RRESP;
                end
                default: ;
            endcase
        end
    end

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

endmodule

// File: tb/tb_axil_master_ctrl.sv
// Bench for axil_master_ctrl: behavioural AXI-Lite slave with programmable wait
// states, a word-array reference model, and negedge protocol monitors.
module tb_axil_master_ctrl;
    localparam int ADDR_W = 32;
    localparam int TMO    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    always #5 clk = ~clk;

    axil_master_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    int tests = 0, fails = 0;

    // ---------------- behavioural slave ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] smem [64];
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_q, wd_q, ar_q;
    logic [3:0]  ws_q;
    logic        aw_now, w_now, b_fire;
    logic [31:0] a_now, d_now;
    logic [3:0]  s_now;

    assign AWREADY = AWVALID && !aw_got && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID && !w_got && (w_cnt >= w_dly);
    assign ARREADY = ARVALID && !ar_got && !RVALID && (ar_cnt >= ar_dly);
    assign aw_now  = aw_got || (AWVALID && AWREADY);
    assign w_now   = w_got || (WVALID && WREADY);
    assign a_now   = aw_got ? aw_q : AWADDR;
    assign d_now   = w_got ? wd_q : WDATA;
    assign s_now   = w_got ? ws_q : WSTRB;
    assign b_fire  = aw_now && w_now && !BVALID && (b_cnt >= b_dly);

    initial for (int i = 0; i < 64; i++) smem[i] = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 0; w_got <= 0; ar_got <= 0; BVALID <= 0; RVALID <= 0;
            BRESP <= 0; RRESP <= 0; RDATA <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_q <= 0; wd_q <= 0; ws_q <= 0; ar_q <= 0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            if (BVALID && BREADY) BVALID <= 0;
            if (b_fire) begin
                BVALID <= 1; aw_got <= 0; w_got <= 0; b_cnt <= 0;
                BRESP  <= (a_now[15:8] != 0) ? 2'b10 : 2'b00;
                if (a_now[15:8] == 0)
                    for (int i = 0; i < 4; i++)
                        if (s_now[i]) smem[a_now[7:2]][8*i +: 8] <= d_now[8*i +: 8];
            end else begin
                if (AWVALID && AWREADY) begin aw_got <= 1; aw_q <= AWADDR; end
                if (WVALID && WREADY) begin w_got <= 1; wd_q <= WDATA; ws_q <= WSTRB; end
                if (aw_now && w_now && !BVALID) b_cnt <= b_cnt + 1;
            end
            if (RVALID && RREADY) RVALID <= 0;
            if (ARVALID && ARREADY) begin
                ar_got <= 1; ar_q <= ARADDR; r_cnt <= 0;
            end else if (ar_got && !RVALID) begin
                if (r_cnt >= r_dly) begin
                    RVALID <= 1; ar_got <= 0;
                    RRESP  <= (ar_q[15:8] != 0) ? 2'b10 : 2'b00;
                    RDATA  <= (ar_q[15:8] != 0) ? 32'h0 : smem[ar_q[7:2]];
                end else r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- protocol monitors (negedge) ----------------
    bit          mon_en = 1;
    int          viol = 0, n_aw = 0, n_w = 0, n_ar = 0, exp_aw = 0, exp_w = 0, exp_ar = 0;
    logic        aw_pend = 0, w_pend = 0, ar_pend = 0;
    logic [31:0] aw_hold, w_hold, ar_hold;
    logic [3:0]  s_hold;
    time         t_aw = 0, t_w = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            aw_pend <= 0; w_pend <= 0; ar_pend <= 0;
        end else begin
            if (mon_en) begin
                if ((aw_pend && (!AWVALID || AWADDR != aw_hold)) ||
                    (w_pend && (!WVALID || WDATA != w_hold || WSTRB != s_hold)) ||
                    (ar_pend && (!ARVALID || ARADDR != ar_hold)) ||
                    (AWVALID && AWADDR[1:0] != 0) || (ARVALID && ARADDR[1:0] != 0) ||
                    (BREADY && (AWVALID || WVALID || ARVALID || cmd_ready || rsp_valid)) ||
                    (RREADY && (AWVALID || WVALID || ARVALID || cmd_ready || rsp_valid)))
                    viol <= viol + 1;
            end
            aw_pend <= AWVALID && !AWREADY; aw_hold <= AWADDR;
            w_pend  <= WVALID && !WREADY;   w_hold  <= WDATA; s_hold <= WSTRB;
            ar_pend <= ARVALID && !ARREADY; ar_hold <= ARADDR;
            if (AWVALID && AWREADY) begin n_aw <= n_aw + 1; t_aw <= $time; end
            if (WVALID && WREADY)   begin n_w <= n_w + 1;   t_w <= $time; end
            if (ARVALID && ARREADY) n_ar <= n_ar + 1;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_mem [64];
    initial for (int i = 0; i < 64; i++) exp_mem[i] = '0;

    // Slave contract: addresses with bits[15:8] set answer SLVERR and touch nothing.
    function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] s, output logic [31:0] erd, output logic [1:0] err);
        bit ok = (a[15:8] == 8'h0);
        int idx = int'(a[7:2]);
        erd = '0;
        err = ok ? 2'b00 : 2'b10;
        if (ok && wr)
            for (int i = 0; i < 4; i++) if (s[i]) exp_mem[idx][8*i +: 8] = d[8*i +: 8];
        if (ok && !wr) erd = exp_mem[idx];
    endfunction

    task automatic run(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, output logic [31:0] rd, output logic [1:0] rr,
                       output logic to, output logic br, output int lat);
        int g = 0;
        rd = '0; rr = '0; to = 0; br = 0; lat = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && g < 100) begin @(negedge clk); g++; end
        if (!cmd_ready) begin
            tests++; fails++; cmd_valid = 0;
            $display("FAIL cmd_accept: cmd_ready=%0b, required 1", cmd_ready);
            return;
        end
        @(negedge clk);
        cmd_valid = 0; lat = 1;
        if (wr) begin exp_aw++; exp_w++; end else exp_ar++;
        while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
        if (!rsp_valid) begin
            tests++; fails++;
            $display("FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, lat);
            return;
        end
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout; br = BREADY;
        repeat (hold) @(negedge clk);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    logic [31:0] rd, erd;
    logic [1:0]  rr, err;
    logic        to, br;
    int          lat;

    task automatic test_reset();
        #12;
        tests++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_timeout} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctl: aw/w/ar/b/r/rsp/to=%b, required 0000000",
                     {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_timeout});
        end
        tests++;
        if ({rsp_rdata, rsp_resp, AWADDR, WDATA, WSTRB} !== '0) begin
            fails++;
            $display("FAIL reset_data: rdata=%h resp=%b awaddr=%h wdata=%h wstrb=%h, required 0",
                     rsp_rdata, rsp_resp, AWADDR, WDATA, WSTRB);
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_write_zero_wait();
        aw_dly = 0; w_dly = 0; b_dly = 0;
        model(1, 32'h0, 32'h2, 4'hF, erd, err);
        run(1, 32'h0, 32'h2, 4'hF, 0, rd, rr, to, br, lat);
        // Accept edge, then WREQ, WRESP, RSP: rsp_valid seen 3 edges after the accept edge.
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL wr_latency: got %0d edges, required 3", lat); end
        tests++;
        if ({rd, rr, to} !== {32'h0, 2'b00, 1'b0}) begin
            fails++; $display("FAIL wr_rsp: rdata=%h resp=%b to=%b, required 0/00/0", rd, rr, to);
        end
        tests++;
        if (t_aw !== t_w) begin fails++; $display("FAIL wr_aw_w_same: aw@%0t w@%0t, required equal", t_aw, t_w); end
        tests++;
        if (smem[0] !== 32'h2) begin fails++; $display("FAIL wr_slave_run: reg0=%h, required 00000002", smem[0]); end
    endtask

    task automatic test_write_w_delayed();
        aw_dly = 0; w_dly = 3; b_dly = 1;
        model(1, 32'h10, 32'h12345678, 4'hF, erd, err);
        run(1, 32'h10, 32'h12345678, 4'hF, 0, rd, rr, to, br, lat);
        tests++;
        if (t_w - t_aw !== 30) begin
            fails++; $display("FAIL wr_w_delay: w-aw=%0t, required 30", t_w - t_aw);
        end
        tests++;
        if (smem[4] !== 32'h12345678) begin
            fails++; $display("FAIL wr_slave_ctrl: reg4=%h, required 12345678", smem[4]);
        end
        tests++;
        if ({n_aw, n_w} !== {exp_aw, exp_w}) begin
            fails++; $display("FAIL wr_hs_count: aw=%0d w=%0d, required %0d", n_aw, n_w, exp_aw);
        end
        w_dly = 0; b_dly = 0;
    endtask

    task automatic test_read_back();
        ar_dly = 2; r_dly = 1;
        model(0, 32'h10, 32'h0, 4'h0, erd, err);
        run(0, 32'h10, 32'h0, 4'h0, 0, rd, rr, to, br, lat);
        tests++;
        if ({rd, rr} !== {32'h12345678, 2'b00}) begin
            fails++; $display("FAIL rd_ctrl: rdata=%h resp=%b, required 12345678/00", rd, rr);
        end
        ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_rsp_hold();
        int g = 0;
        int aw0;
        logic [31:0] held;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0; cmd_wdata = 32'hDEAD; cmd_wstrb = 4'hF;
        exp_ar++;
        while (!rsp_valid && g < 50) begin @(negedge clk); g++; end
        held = rsp_rdata; aw0 = n_aw;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({rsp_valid, cmd_ready, rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
                fails++;
                $display("FAIL rsp_hold[%0d]: valid=%b cmd_ready=%b rdata=%h, required 1/0/12345678",
                         i, rsp_valid, cmd_ready, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1;
        tests++;
        if ({cmd_ready, rsp_rdata} !== {1'b0, held}) begin
            fails++; $display("FAIL rsp_hs_cycle: cmd_ready=%b, required 0", cmd_ready);
        end
        @(negedge clk);
        rsp_ready = 0; cmd_valid = 0;
        tests++;
        if ({cmd_ready, rsp_valid} !== 2'b10 || n_aw !== aw0) begin
            fails++; $display("FAIL rsp_after: cmd_ready=%b rsp_valid=%b aw=%0d, required 1/0/%0d",
                              cmd_ready, rsp_valid, n_aw, aw0);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [3:0]  s;
        bit          wr;
        for (int n = 0; n < 40; n++) begin
            wr = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a | 32'h100;
            d  = $urandom; s = 4'($urandom_range(0, 15));
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            model(wr, a, d, s, erd, err);
            run(wr, a, d, s, $urandom_range(0, 3), rd, rr, to, br, lat);
            tests++;
            if ({rd, rr, to} !== {erd, err, 1'b0}) begin
                fails++;
                $display("FAIL rand[%0d] %s a=%h: rdata=%h resp=%b to=%b, required %h/%b/0",
                         n, wr ? "wr" : "rd", a, rd, rr, to, erd, err);
            end
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_reset_mid_read();
        int g = 0;
        r_dly = 20;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
        @(negedge clk);
        cmd_valid = 0; exp_ar++;
        while (!RREADY && g < 20) begin @(negedge clk); g++; end
        #2 rst_n = 0;
        #1;
        tests++;
        if ({RREADY, rsp_valid} !== 2'b00) begin
            fails++; $display("FAIL rst_mid_rd: rready=%b rsp_valid=%b, required 00", RREADY, rsp_valid);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_no_rsp: rsp_valid=%b, required 0", rsp_valid); end
        rst_n = 1; r_dly = 0;
        model(0, 32'h10, 32'h0, 4'h0, erd, err);
        run(0, 32'h10, 32'h0, 4'h0, 0, rd, rr, to, br, lat);
        tests++;
        if ({rd, rr} !== {erd, err}) begin
            fails++; $display("FAIL rd_after_rst: rdata=%h resp=%b, required %h/%b", rd, rr, erd, err);
        end
    endtask

`ifdef AXIL_MST_TIMEOUT_EN
    task automatic test_timeout();
        mon_en = 0; b_dly = 100000;
        run(1, 32'h20, 32'hCAFE, 4'hF, 0, rd, rr, to, br, lat);
        // 16 waiting cycles after the accept edge, rsp_valid on the next one.
        tests++;
        if (lat !== TMO + 1) begin fails++; $display("FAIL tmo_latency: got %0d, required %0d", lat, TMO + 1); end
        tests++;
        if ({to, rr, rd, br} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
            fails++; $display("FAIL tmo_rsp: to=%b resp=%b rdata=%h bready=%b, required 1/10/0/0", to, rr, rd, br);
        end
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        b_dly = 0; mon_en = 1;
    endtask
`endif

    task automatic test_protocol();
        tests++;
        if (viol !== 0) begin fails++; $display("FAIL protocol: %0d violations, required 0", viol); end
        tests++;
        if ({n_aw, n_w, n_ar} !== {exp_aw, exp_w, exp_ar}) begin
            fails++; $display("FAIL hs_totals: aw=%0d w=%0d ar=%0d, required %0d/%0d/%0d",
                              n_aw, n_w, n_ar, exp_aw, exp_w, exp_ar);
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_w_delayed();
        test_read_back();
        test_rsp_hold();
        test_random();
        test_reset_mid_read();
`ifdef AXIL_MST_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
